// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues reads to a 1-cycle synchronous IMEM and
// buffers {pc, inst} pairs in a small circular queue feeding decode.
module fetch_unit #(
  parameter int unsigned ADDR_W   = 13,
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_en,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [31:0]              imem_rdata,
  output logic                     inst_valid,
  output logic [31:0]              inst,
  output logic [31:0]              inst_pc,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   fq_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W:0]   credit_t;

  logic [31:0]       r_fetch_pc;
  logic              r_inflight;
  logic [31:0]       r_infl_pc;
  logic [ADDR_W-1:0] r_addr;

  logic [31:0]       r_q_pc   [DEPTH];
  logic [31:0]       r_q_inst [DEPTH];
  ptr_t              r_rd_ptr;
  ptr_t              r_wr_ptr;
  cnt_t              r_count;

  logic              r_valid;
  logic [31:0]       r_inst;
  logic [31:0]       r_inst_pc;

  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  credit_t           w_credit;
  cnt_t              w_cnt_after_pop;
  cnt_t              w_next_count;
  ptr_t              w_next_rd;
  logic              w_head_from_push;

  assign w_pop    = r_valid && inst_ready && !redirect_valid;
  assign w_push   = r_inflight && !redirect_valid;
  assign w_credit = credit_t'(r_count) + credit_t'(r_inflight) - credit_t'(w_pop);
  assign w_issue  = !rst && !redirect_valid && (w_credit < credit_t'(DEPTH));

  assign w_cnt_after_pop  = r_count - cnt_t'(w_pop);
  assign w_next_count     = w_cnt_after_pop + cnt_t'(w_push);
  assign w_next_rd        = r_rd_ptr + ptr_t'(w_pop);
  assign w_head_from_push = w_push && (w_cnt_after_pop == '0);

  assign imem_en    = w_issue;
  assign imem_addr  = w_issue ? r_fetch_pc[ADDR_W+1:2] : r_addr;
  assign inst_valid = r_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign fq_count   = r_count;

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_q_pc[r_wr_ptr]   <= r_infl_pc;
      r_q_inst[r_wr_ptr] <= imem_rdata;
    end
  end

  // Head outputs are dedicated registers loaded with the next head entry, so
  // they hold their last value when the queue drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_inflight <= 1'b0;
      r_infl_pc  <= '0;
      r_addr     <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_inst     <= '0;
      r_inst_pc  <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc & ~32'h3;
      r_inflight <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ptr_t'(1);
      r_rd_ptr <= w_next_rd;
      r_count  <= w_next_count;
      r_valid  <= (w_next_count != '0);
      if (w_next_count != '0) begin
        if (w_head_from_push) begin
          r_inst    <= imem_rdata;
          r_inst_pc <= r_infl_pc;
        end else begin
          r_inst    <= r_q_inst[w_next_rd];
          r_inst_pc <= r_q_pc[w_next_rd];
        end
      end
      r_inflight <= w_issue;
      if (w_issue) begin
        r_infl_pc  <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_addr     <= r_fetch_pc[ADDR_W+1:2];
      end
    end
  end

endmodule
